decimal_entry: RTL and testbench
================================

Name: decimal_entry

Overview:
- Operand-entry front end for the Abacus ALU: the input-side counterpart to the binary→BCD→seven-segment output path.
- The user dials a 3-digit decimal number with push buttons (digit select, increment, decrement, enter).
- The block debounces the buttons, holds three BCD digits, and on enter serially converts BCD→binary (×10 accumulate).
- It presents an 8-bit operand with a one-cycle valid pulse and an overflow flag; the BCD digits and cursor drive the existing seven-segment path.

Parameters:
- DEB_CYCLES, 1_000_000, consecutive stable cycles required before a debounced button level changes (10 ms at 100 MHz).
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  in  1  system clock, 100 MHz
- clr_n  in  1  synchronous active-low reset
- btn_inc  in  1  raw button: selected digit +1
- btn_dec  in  1  raw button: selected digit −1
- btn_sel  in  1  raw button: move cursor to the next digit
- btn_ent  in  1  raw button: convert and publish
- disp_bcd  out  12  {hundreds, tens, ones} BCD for the display mux
- cursor  out  2  selected digit: 0=ones, 1=tens, 2=hundreds
- busy  out  1  high while converting
- value  out  8  last converted operand
- value_valid  out  1  one-cycle pulse when value updates
- ovf  out  1  last conversion exceeded 255; sticky until next conversion

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low: clr_n sampled low on a clk edge resets every register.
- Reset values: disp_bcd=0, cursor=0, busy=0, value=0, value_valid=0, ovf=0, state=EDIT. All debounce counters and synchronisers are 0 and debounced levels are 0.
- Reset during CONV or DONE aborts the conversion; no value_valid is produced.
- Debounce, per button:
  - 2-flop synchroniser.
  - Counter clears whenever the synchronised input equals the debounced level.
  - Otherwise the counter increments; when it reaches DEB_CYCLES−1 the debounced level toggles and the counter clears.
  - Event = one-cycle pulse on the debounced rising edge. Releases produce no event.
- EDIT state (busy=0):
  - inc event: digit[cursor] = (digit==9) ? 0 : digit+1.
  - dec event: digit[cursor] = (digit==0) ? 9 : digit−1.
  - sel event: cursor = (cursor==2) ? 0 : cursor+1.
  - Simultaneous events in one cycle: priority ent > sel > inc > dec. Lower-priority events in that cycle are discarded.
  - ent event: acc(10b)=0, idx=2, go to CONV.
- CONV state (busy=1), exactly 3 cycles:
  - Each cycle: acc = acc*10 + digit[idx], idx−1. Implement *10 as (acc<<3)+(acc<<1).
  - After idx 0 is processed, go to DONE.
  - All button events arriving during CONV or DONE are dropped, not queued.
  - Digits and cursor are frozen.
- DONE state (1 cycle):
  - value_valid=1.
  - value = (acc>255) ? 8'hFF : acc[7:0].
  - ovf = (acc>255).
  - busy=0. Next state is EDIT.
- Latency: if the ent event is high in cycle k, busy is high in cycles k+1..k+3 and value_valid is high in cycle k+4 only.
- value and ovf hold between conversions. disp_bcd always reflects the current digits.

Decomposition:
- Package abacus_entry_pkg:
  - state encoding EDIT/CONV/DONE (2-bit localparams)
  - BCD_W=4, N_DIGITS=3, ACC_W=10, MAX_OPERAND=255
- Sub-module btn_debounce (params DEB_CYCLES, CNT_W; ports clk, clr_n, raw, level, rise), instantiated four times.
- The FSM, digit registers and converter stay in decimal_entry.

Test Plan (DEB_CYCLES=4, CNT_W=3):
1. Reset: hold clr_n=0 with all buttons pressed for 10 cycles, then release → all outputs 0, no events in the first 5 cycles after release.
2. Debounce: btn_inc glitch high for 2 cycles → digit unchanged. Hold high for 10 cycles → ones goes 0→1 exactly once. Release, then hold again → ones=2.
3. Wrap: press dec at ones=0 → 9. Press sel three times → cursor 0→1→2→0.
4. Conversion: set digits 1,2,8 and press ent (event at cycle k) → busy at k+1..k+3, value_valid only at k+4, value=128, ovf=0.
5. Overflow and priority: digits 9,9,9, press ent and inc in the same cycle → no digit change, value=8'hFF, ovf=1. Then enter 0,0,7 → value=7, ovf=0.
6. Abort and drop: press sel during CONV → cursor unchanged. Drive clr_n=0 at k+2 → no value_valid, value stays at its reset value 0.

Source files
------------

// File: rtl/abacus_entry_pkg.sv
// Shared types and constants for the Abacus decimal operand-entry front end.
// Holds the FSM encoding, digit/accumulator widths and small BCD helpers.
package abacus_entry_pkg;

  localparam int BCD_W       = 4;
  localparam int N_DIGITS    = 3;
  localparam int ACC_W       = 10;
  localparam int MAX_OPERAND = 255;

  localparam logic [1:0] ST_EDIT = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    EDIT = ST_EDIT,
    CONV = ST_CONV,
    DONE = ST_DONE
  } state_t;

  // Bit positions of the four button events inside the event vector
  localparam int EV_DEC = 0;
  localparam int EV_INC = 1;
  localparam int EV_SEL = 2;
  localparam int EV_ENT = 3;
  localparam int N_BTN  = 4;

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    return (d == BCD_W'(9)) ? '0 : d + 1'b1;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] d);
    return (d == '0) ? BCD_W'(9) : d - 1'b1;
  endfunction

  function automatic logic [1:0] cursor_next(input logic [1:0] c);
    return (c == 2'(N_DIGITS - 1)) ? 2'd0 : c + 2'd1;
  endfunction

  function automatic logic [BCD_W-1:0] digit_at(
    input logic [N_DIGITS*BCD_W-1:0] digits,
    input logic [1:0]                idx
  );
    logic [BCD_W-1:0] d;
    case (idx)
      2'd1:    d = digits[BCD_W +: BCD_W];
      2'd2:    d = digits[2*BCD_W +: BCD_W];
      default: d = digits[0 +: BCD_W];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: 2-flop synchroniser, stability counter and
// a one-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic clr_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // Level flips together with the pulse, so rise implies level
        r_cnt   <= '0;
        r_level <= ~r_level;
        r_rise  <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/decimal_entry.sv
// Three-digit decimal operand entry: buttons edit BCD digits, enter runs a
// serial x10 accumulate and publishes a saturated 8-bit operand.
module decimal_entry
  import abacus_entry_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_W      = 20
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic                      btn_inc,
  input  logic                      btn_dec,
  input  logic                      btn_sel,
  input  logic                      btn_ent,
  output logic [N_DIGITS*BCD_W-1:0] disp_bcd,
  output logic [1:0]                cursor,
  output logic                      busy,
  output logic [7:0]                value,
  output logic                      value_valid,
  output logic                      ovf
);

  logic [N_BTN-1:0]          w_raw;
  logic [N_BTN-1:0]          w_level;
  logic [N_BTN-1:0]          w_rise;
  logic [N_BTN-1:0]          w_evt;
  logic [N_DIGITS*BCD_W-1:0] w_digits;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [1:0]                r_cursor;
  logic [ACC_W-1:0]          r_acc;
  logic [1:0]                r_idx;
  logic [7:0]                r_value;
  logic                      r_ovf;

  logic                      w_do_ent;
  logic                      w_do_sel;
  logic                      w_do_inc;
  logic                      w_do_dec;
  logic [BCD_W-1:0]          w_cur_digit;
  logic [BCD_W-1:0]          w_conv_digit;
  logic [ACC_W-1:0]          w_acc_next;
  logic                      w_acc_ovf;

  assign w_raw[EV_DEC] = btn_dec;
  assign w_raw[EV_INC] = btn_inc;
  assign w_raw[EV_SEL] = btn_sel;
  assign w_raw[EV_ENT] = btn_ent;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
      ) u_deb (
        .clk  (clk),
        .clr_n(clr_n),
        .raw  (w_raw[gi]),
        .level(w_level[gi]),
        .rise (w_rise[gi])
      );
      assign w_evt[gi] = w_rise[gi] & w_level[gi];
    end
  endgenerate

  // Events only act in EDIT; one per cycle, ent > sel > inc > dec
  always_comb begin
    w_do_ent = 1'b0;
    w_do_sel = 1'b0;
    w_do_inc = 1'b0;
    w_do_dec = 1'b0;
    if (r_state == EDIT) begin
      if (w_evt[EV_ENT])      w_do_ent = 1'b1;
      else if (w_evt[EV_SEL]) w_do_sel = 1'b1;
      else if (w_evt[EV_INC]) w_do_inc = 1'b1;
      else if (w_evt[EV_DEC]) w_do_dec = 1'b1;
    end
  end

  assign w_cur_digit  = digit_at(w_digits, r_cursor);
  assign w_conv_digit = digit_at(w_digits, r_idx);
  assign w_acc_next   = (r_acc << 3) + (r_acc << 1) + ACC_W'(w_conv_digit);
  assign w_acc_ovf    = (w_acc_next > ACC_W'(MAX_OPERAND));

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      logic [BCD_W-1:0] r_digit;
      always_ff @(posedge clk) begin
        if (!clr_n) begin
          r_digit <= '0;
        end else if (r_cursor == 2'(gi)) begin
          if (w_do_inc)      r_digit <= bcd_inc(w_cur_digit);
          else if (w_do_dec) r_digit <= bcd_dec(w_cur_digit);
        end
      end
      assign w_digits[gi*BCD_W +: BCD_W] = r_digit;
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EDIT:    if (w_do_ent) w_state_next = CONV;
      CONV:    if (r_idx == 2'd0) w_state_next = DONE;
      DONE:    w_state_next = EDIT;
      default: w_state_next = EDIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state  <= EDIT;
      r_cursor <= 2'd0;
      r_acc    <= '0;
      r_idx    <= 2'd0;
      r_value  <= 8'd0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_do_sel) r_cursor <= cursor_next(r_cursor);
      if (w_do_ent) begin
        r_acc <= '0;
        r_idx <= 2'(N_DIGITS - 1);
      end
      if (r_state == CONV) begin
        r_acc <= w_acc_next;
        r_idx <= r_idx - 2'd1;
        // Publish on the final accumulate so value is stable during DONE
        if (r_idx == 2'd0) begin
          r_value <= w_acc_ovf ? 8'hFF : w_acc_next[7:0];
          r_ovf   <= w_acc_ovf;
        end
      end
    end
  end

  assign disp_bcd    = w_digits;
  assign cursor      = r_cursor;
  assign busy        = (r_state == CONV);
  assign value_valid = (r_state == DONE);
  assign value       = r_value;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_decimal_entry.sv
// Scoreboard bench for decimal_entry with a short debounce window: a digit
// model predicts edits, and conversions are queued and matched on value_valid.
module tb_decimal_entry;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        btn_inc, btn_dec, btn_sel, btn_ent;
  logic [11:0] disp_bcd;
  logic [1:0]  cursor;
  logic        busy;
  logic [7:0]  value;
  logic        value_valid;
  logic        ovf;

  decimal_entry #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .btn_sel    (btn_sel),
    .btn_ent    (btn_ent),
    .disp_bcd   (disp_bcd),
    .cursor     (cursor),
    .busy       (busy),
    .value      (value),
    .value_valid(value_valid),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at_cyc;
    logic [7:0] val;
    logic       ov;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  int         m_dig[3];
  int         m_cur = 0;
  logic [7:0] m_val = 8'd0;
  logic       m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic logic [11:0] m_disp();
    return {4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
  endfunction

  task automatic push_conv(input int k);
    int d;
    d = m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
    m_val = (d > 255) ? 8'hFF : 8'(d);
    m_ovf = (d > 255);
    sb.push_back('{k + 4, m_val, m_ovf});
    $display("push conv digits=%0d%0d%0d exp value=%0d ovf=%0b at cycle %0d",
             m_dig[2], m_dig[1], m_dig[0], m_val, m_ovf, k + 4);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_disp"}, 32'(disp_bcd), 32'(m_disp()));
    chk({tag, "_cursor"}, 32'(cursor), 32'(m_cur));
    chk({tag, "_value"}, 32'(value), 32'(m_val));
    chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
  endtask

  // mask = {ent, sel, inc, dec}; the event lands 6 cycles after the raw rise
  task automatic press(input logic [3:0] mask, input int hold);
    int  n, k;
    bit  ev;
    n  = cyc;
    k  = n + 6;
    ev = (hold >= DEB);
    if (ev && mask[3]) push_conv(k);
    {btn_ent, btn_sel, btn_inc, btn_dec} = mask;
    for (int i = 0; i < 22; i++) begin
      if (i == hold) {btn_ent, btn_sel, btn_inc, btn_dec} = 4'b0000;
      @(posedge clk); #1;
      if (ev && mask[3]) chk("busy", 32'(busy), 32'(cyc >= k + 1 && cyc <= k + 3));
    end
    if (ev && !mask[3]) begin
      if (mask[2])      m_cur = (m_cur == 2) ? 0 : m_cur + 1;
      else if (mask[1]) m_dig[m_cur] = (m_dig[m_cur] == 9) ? 0 : m_dig[m_cur] + 1;
      else if (mask[0]) m_dig[m_cur] = (m_dig[m_cur] == 0) ? 9 : m_dig[m_cur] - 1;
    end
    $display("press mask=%b hold=%0d -> disp=%03h cursor=%0d value=%0d ovf=%0b",
             mask, hold, disp_bcd, cursor, value, ovf);
    check_state("press");
  endtask

  // Every value_valid must match the oldest queued conversion, on its cycle
  always @(posedge clk) begin
    #1;
    if (value_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'(value_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("valid value=%0d ovf=%0b cycle=%0d", value, ovf, cyc);
        chk("valid_cycle", 32'(cyc), 32'(e.at_cyc));
        chk("valid_value", 32'(value), 32'(e.val));
        chk("valid_ovf", 32'(ovf), 32'(e.ov));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    m_dig = '{0, 0, 0};

    // Reset held with every button pressed
    clr_n = 1'b0;
    {btn_ent, btn_sel, btn_inc, btn_dec} = 4'b1111;
    repeat (10) @(posedge clk);
    #1;
    clr_n = 1'b1;
    {btn_ent, btn_sel, btn_inc, btn_dec} = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("reset_outputs", {8'd0, disp_bcd, cursor, busy, value, value_valid, ovf}, 32'd0);
    end

    // Debounce: glitch ignored, long presses count once each
    press(4'b0010, 2);
    press(4'b0010, 10);
    press(4'b0010, 10);

    // Wrap-around on dec and cursor
    press(4'b0001, 10);
    press(4'b0001, 10);
    press(4'b0001, 10);
    press(4'b0100, 10);
    press(4'b0100, 10);
    press(4'b0100, 10);

    // Build 1,2,8 and convert
    press(4'b0001, 10);
    press(4'b0100, 10);
    press(4'b0010, 10);
    press(4'b0010, 10);
    press(4'b0100, 10);
    press(4'b0010, 10);
    press(4'b1000, 10);

    // Build 9,9,9 then ent and inc together
    press(4'b0001, 10);
    press(4'b0001, 10);
    press(4'b0100, 10);
    press(4'b0010, 10);
    press(4'b0100, 10);
    press(4'b0001, 10);
    press(4'b0001, 10);
    press(4'b0001, 10);
    press(4'b1010, 10);

    // Build 0,0,7 and convert
    press(4'b0010, 10);
    press(4'b0100, 10);
    press(4'b0010, 10);
    press(4'b0100, 10);
    press(4'b0001, 10);
    press(4'b0001, 10);
    press(4'b1000, 10);

    // sel event lands mid-conversion and must be dropped
    n = cyc;
    k = n + 6;
    push_conv(k);
    btn_ent = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 2)  btn_sel = 1'b1;
      if (i == 10) btn_ent = 1'b0;
      if (i == 12) btn_sel = 1'b0;
      @(posedge clk); #1;
    end
    $display("sel during conv -> disp=%03h cursor=%0d value=%0d", disp_bcd, cursor, value);
    check_state("drop_sel");

    // Reset sampled at the end of cycle k+2 aborts the conversion
    n = cyc;
    k = n + 6;
    btn_ent = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cyc == k + 2) begin
        clr_n   = 1'b0;
        btn_ent = 1'b0;
      end
      if (cyc == k + 3) clr_n = 1'b1;
      @(posedge clk); #1;
      if (cyc == k + 1) chk("abort_busy", 32'(busy), 32'd1);
    end
    m_dig = '{0, 0, 0};
    m_cur = 0;
    m_val = 8'd0;
    m_ovf = 1'b0;
    $display("abort -> disp=%03h cursor=%0d busy=%0b value=%0d", disp_bcd, cursor, busy, value);
    check_state("abort");
    chk("abort_busy_low", 32'(busy), 32'd0);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
